// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute-stage core and the divider.
//   start     : one-cycle request strobe (core -> divider)
//   operand1  : dividend (core -> divider)
//   operand2  : divisor (core -> divider)
//   operation : 00 DIV, 01 DIVU, 10 REM, 11 REMU (core -> divider)
//   busy      : divider occupied, core must stall (divider -> core)
//   valid     : one-cycle completion pulse (divider -> core)
//   result    : quotient or remainder, held until next completion (divider -> core)
interface div_unit_if;
    logic        start;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [1:0]  operation;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    modport master (
        output start, operand1, operand2, operation,
        input  busy, valid, result
    );

    modport slave (
        input  start, operand1, operand2, operation,
        output busy, valid, result
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV, DIVU, REM, REMU).
// Restoring shift-subtract, one quotient bit per cycle (32 cycles), with a
// one-cycle fast path for divide-by-zero and signed overflow.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : div_unit_if slave modport (start/operands/operation in,
//         busy/valid/result out; all outputs registered)
module div_unit (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    rem;       // partial remainder
    logic [W-1:0]    dvd;       // dividend magnitude, quotient bits shift in at LSB
    logic [W-1:0]    dvs;       // divisor magnitude
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;
    logic            want_rem;

    logic            a_neg_c;
    logic            b_neg_c;
    logic [W-1:0]    a_mag_c;
    logic [W-1:0]    b_mag_c;
    logic            div0_c;
    logic            ovf_c;
    logic [W:0]      shifted_c;
    logic [W:0]      trial_c;
    logic [W-1:0]    rem_nxt_c;
    logic [W-1:0]    dvd_nxt_c;
    logic [W-1:0]    q_fix_c;
    logic [W-1:0]    r_fix_c;

    // Operand decode and one restoring iteration.
    always_comb begin
        // operation[0] = unsigned, operation[1] = remainder
        a_neg_c   = ~bus.operation[0] & bus.operand1[W-1];
        b_neg_c   = ~bus.operation[0] & bus.operand2[W-1];
        a_mag_c   = a_neg_c ? (W'(0) - bus.operand1) : bus.operand1;
        b_mag_c   = b_neg_c ? (W'(0) - bus.operand2) : bus.operand2;
        div0_c    = (bus.operand2 == '0);
        ovf_c     = ~bus.operation[0] && (bus.operand1 == 32'h8000_0000)
                    && (bus.operand2 == 32'hFFFF_FFFF);

        // Shifted remainder can reach 33 bits when the divisor exceeds 2^31.
        shifted_c = {rem, dvd[W-1]};
        trial_c   = shifted_c - {1'b0, dvs};
        // trial_c[W] is the borrow: set means the trial went negative.
        rem_nxt_c = trial_c[W] ? shifted_c[W-1:0] : trial_c[W-1:0];
        dvd_nxt_c = {dvd[W-2:0], ~trial_c[W]};

        q_fix_c   = q_neg ? (W'(0) - dvd_nxt_c) : dvd_nxt_c;
        r_fix_c   = r_neg ? (W'(0) - rem_nxt_c) : rem_nxt_c;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            cnt        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            want_rem   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.valid  <= 1'b0;
            bus.result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.valid <= 1'b0;
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (div0_c) begin
                            bus.result <= bus.operation[1] ? bus.operand1 : 32'hFFFF_FFFF;
                            bus.valid  <= 1'b1;
                            state      <= DONE;
                        end else if (ovf_c) begin
                            bus.result <= bus.operation[1] ? 32'h0000_0000 : 32'h8000_0000;
                            bus.valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            dvd      <= a_mag_c;
                            dvs      <= b_mag_c;
                            rem      <= '0;
                            cnt      <= '0;
                            q_neg    <= a_neg_c ^ b_neg_c;
                            r_neg    <= a_neg_c;
                            want_rem <= bus.operation[1];
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt_c;
                    dvd <= dvd_nxt_c;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        bus.result <= want_rem ? r_fix_c : q_fix_c;
                        bus.valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.valid <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.valid <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Latency is counted in falling edges after the accepting edge E0; the value
// seen at falling edge n is what the core samples at rising edge En.
module tb_div_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and check latency, busy span, result, and the idle cycle after.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        int lat;
        int busy_cnt;
        logic [31:0] res;
        lat = 0;
        busy_cnt = 0;
        res = 'x;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operand1  = a;
        bus.operand2  = b;
        bus.operation = op;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.valid) begin
                lat = k;
                res = bus.result;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat));
        @(negedge clk);
        chk({tag, "_post"}, {29'd0, bus.busy, bus.valid, 1'b0}, 32'd0);
        chk({tag, "_hold"}, bus.result, exp_res);
    endtask

    initial begin
        int lat;
        int pulses;
        int busy_seen;
        logic [31:0] res;

        checks        = 0;
        failures      = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.operation = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_valid", {31'd0, bus.valid}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned
        run_op(32'd100, 32'd7, 2'b01, 32'd14, 33, "divu_100_7");
        run_op(32'd100, 32'd7, 2'b11, 32'd2, 33, "remu_100_7");
        // Signed
        run_op(32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(32'hFFFF_FFF9, 32'd2, 2'b10, 32'hFFFF_FFFF, 33, "rem_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 2'b00, 32'hFFFF_FFFD, 33, "div_7_m2");
        run_op(32'd7, 32'hFFFF_FFFE, 2'b10, 32'd1, 33, "rem_7_m2");
        // Divide by zero
        run_op(32'h1234_5678, 32'd0, 2'b00, 32'hFFFF_FFFF, 1, "div_by0");
        run_op(32'h1234_5678, 32'd0, 2'b01, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(32'h1234_5678, 32'd0, 2'b10, 32'h1234_5678, 1, "rem_by0");
        run_op(32'h1234_5678, 32'd0, 2'b11, 32'h1234_5678, 1, "remu_by0");
        // Signed overflow and the unsigned counterpart
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 1, "div_ovf");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000, 1, "rem_ovf");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000, 33, "divu_ovf_ops");

        // start while busy is ignored
        lat = 0;
        pulses = 0;
        res = 'x;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operand1  = 32'hFFFF_FFFF;
        bus.operand2  = 32'h10;
        bus.operation = 2'b01;
        @(posedge clk);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 5) begin
                bus.start    = 1'b1;
                bus.operand1 = 32'd9;
                bus.operand2 = 32'd3;
            end
            if (k == 6) bus.start = 1'b0;
            if (bus.valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    res = bus.result;
                end
            end
        end
        chk("busy_ign_lat", 32'(lat), 32'd33);
        chk("busy_ign_res", res, 32'h0FFF_FFFF);
        chk("busy_ign_pulses", 32'(pulses), 32'd1);

        // Reset in the middle of a DIV
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operand1  = 32'd100;
        bus.operand2  = 32'd7;
        bus.operation = 2'b00;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.valid) pulses++;
        end
        chk("rst_mid_no_valid", 32'(pulses), 32'd0);
        run_op(32'd20, 32'd4, 2'b01, 32'd5, 33, "divu_20_4");

        // Reset and start on the same edge: request dropped
        @(negedge clk);
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.operand1  = 32'd50;
        bus.operand2  = 32'd5;
        bus.operation = 2'b01;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        busy_seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy || bus.valid) busy_seen++;
        end
        chk("rst_start_dropped", 32'(busy_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
